replay_buffer_ctrl: RTL

Ten-entry, 16-bit retransmit store and its sequencer, directly upstream of the 10:1 word mux `mux10`. Transmitted words are written into slots d0..d9 in circular order and held until acknowledged; on a NAK (or timeout) the block replays every outstanding word oldest-first by stepping the mux select `s`. The mux output `y` is the replay data, qualified by `rp_valid`.

---
 rtl/replay_buffer_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/replay_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// replay_buffer_ctrl
//   Ten-entry retransmit store plus replay sequencer. It sits directly in
//   front of the external 10:1 word mux (mux10). Transmitted words are kept
//   in slots d0..d9 in circular order until they are acknowledged. On a NAK
//   (or, optionally, a timeout) every outstanding word is replayed
//   oldest-first by stepping the mux select s.
//
//   Optional feature macro: REPLAY_TIMER_EN
//     When it is defined, an 8-bit idle timer raises an automatic NAK after
//     TIMEOUT idle cycles without an ACK. When it is undefined, replay
//     starts only on nak.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   wr_en      in   push wr_data into the slot at tail
//   wr_data    in   word to store (DW bits)
//   wr_ready   out  write accepted this cycle when high
//   ack        in   release the oldest entry (head)
//   nak        in   request a replay starting from head
//   rp_ready   in   downstream accepts the current replay word
//   rp_valid   out  mux output y holds a valid replay word
//   d0..d9     out  registered storage slots, wired to the mux data inputs
//   s          out  mux select (0..9)
//   count      out  number of outstanding entries (0..10)
//   replaying  out  high while in REPLAY
// ---------------------------------------------------------------------------
module replay_buffer_ctrl #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          ack,
  input  logic          nak,
  input  logic          rp_ready,
  output logic          rp_valid,
  output logic [DW-1:0] d0,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2,
  output logic [DW-1:0] d3,
  output logic [DW-1:0] d4,
  output logic [DW-1:0] d5,
  output logic [DW-1:0] d6,
  output logic [DW-1:0] d7,
  output logic [DW-1:0] d8,
  output logic [DW-1:0] d9,
  output logic [3:0]    s,
  output logic [3:0]    count,
  output logic          replaying
);

  typedef enum logic {IDLE, REPLAY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    head_q, head_d;
  logic [3:0]    tail_q, tail_d;
  logic [3:0]    rp_ptr_q, rp_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    count_aa;      // occupancy after this cycle's ACK, before the write
  logic [3:0]    rp_ptr_inc;
  logic          wr_fire, ack_fire, nak_req, timeout_hit;
  logic [DW-1:0] slot_q [10];

  // Modulo-10 pointer increment: 9 wraps to 0.
  function automatic logic [3:0] inc10(input logic [3:0] p);
    return (p == 4'd9) ? 4'd0 : p + 4'd1;
  endfunction

  // All outputs decode from registers only.
  assign wr_ready  = (state_q == IDLE) && (count_q < 4'd10);
  assign rp_valid  = (state_q == REPLAY);
  assign replaying = (state_q == REPLAY);
  assign s         = (state_q == REPLAY) ? rp_ptr_q : head_q;
  assign count     = count_q;

  assign wr_fire    = wr_en && wr_ready;
  assign ack_fire   = ack && (count_q != 4'd0);
  assign rp_ptr_inc = inc10(rp_ptr_q);

`ifdef REPLAY_TIMER_EN
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);
  logic [7:0] timer_q, timer_d;

  // The expiry is seen on the registered timer, so it acts as a NAK on the
  // edge that follows the one on which the timer reached TIMEOUT.
  assign timeout_hit = (state_q == IDLE) && (count_q != 4'd0) && (timer_q == TIMEOUT_V);

  always_comb begin
    timer_d = timer_q;
    if (ack || wr_fire || nak || timeout_hit || state_q != IDLE || state_d == REPLAY)
      timer_d = 8'd0;
    else if (count_q != 4'd0)
      timer_d = timer_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= 8'd0;
    else     timer_q <= timer_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign nak_req = nak || timeout_hit;

  always_comb begin
    head_d   = ack_fire ? inc10(head_q) : head_q;
    tail_d   = wr_fire  ? inc10(tail_q) : tail_q;
    count_aa = count_q - {3'd0, ack_fire};
    count_d  = count_aa + {3'd0, wr_fire};
    state_d  = state_q;
    rp_ptr_d = rp_ptr_q;
    case (state_q)
      IDLE: begin
        if (nak_req && count_aa != 4'd0) begin
          state_d  = REPLAY;
          rp_ptr_d = head_d;
        end
      end
      REPLAY: begin
        // Writes are blocked in REPLAY, so count_aa is the next occupancy.
        if (count_aa == 4'd0) begin
          state_d = IDLE;
        end else if (nak) begin
          // Restart from the (post-ACK) head; any accepted beat is discarded.
          rp_ptr_d = head_d;
        end else if (rp_ready) begin
          rp_ptr_d = rp_ptr_inc;
          if (rp_ptr_inc == tail_q) state_d = IDLE;
        end else if (ack_fire && rp_ptr_q == head_q) begin
          // The word about to be replayed was just released; follow head.
          rp_ptr_d = head_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= 4'd0;
      tail_q   <= 4'd0;
      rp_ptr_q <= 4'd0;
      count_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      rp_ptr_q <= rp_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage slots. Each slot has its own register so it can be wired
  // straight to a mux input.
  for (genvar gi = 0; gi < 10; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        slot_q[gi] <= '0;
      else if (wr_fire && tail_q == 4'(gi))
        slot_q[gi] <= wr_data;
    end
  end

  assign d0 = slot_q[0];
  assign d1 = slot_q[1];
  assign d2 = slot_q[2];
  assign d3 = slot_q[3];
  assign d4 = slot_q[4];
  assign d5 = slot_q[5];
  assign d6 = slot_q[6];
  assign d7 = slot_q[7];
  assign d8 = slot_q[8];
  assign d9 = slot_q[9];

endmodule
